sequence_detector_fsm_101001: RTL and testbench

- Serial bit-stream pattern detector: one bit per clock on i_data; flags each occurrence of the 6-bit sequence 1-0-1-0-0-1, first bit received first.
- Implemented as a Moore FSM with a registered one-cycle pulse output.
- Used as a leaf block in serial-protocol front ends; output feeds downstream framing/alignment logic.

---
 rtl/sequence_detector_fsm_101001.sv | 64 ++++++
 tb/tb_sequence_detector_fsm_101001.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sequence_detector_fsm_101001.sv
// Serial detector for the bit pattern 1-0-1-0-0-1 (first bit first).
// Moore FSM with a registered one-cycle match pulse; OVERLAP selects suffix reuse.
module sequence_detector_fsm_101001 #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_data,
  output logic o_pattern_found
);

  // Each state names the longest prefix of 101001 matched so far.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    SF = 3'd6
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge i_clk) begin
    if (i_resetn) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S0;
    case (state)
      S0: state_next = i_data ? S1 : S0;
      S1: state_next = i_data ? S1 : S2;
      S2: state_next = i_data ? S3 : S0;
      S3: state_next = i_data ? S1 : S4;
      S4: state_next = i_data ? S3 : S5;
      S5: state_next = i_data ? SF : S0;
      SF: begin
        // With overlap, the trailing "1" and "10" of a match seed the next one.
        if (i_data) begin
          state_next = S1;
        end else begin
          state_next = OVERLAP ? S2 : S0;
        end
      end
      default: state_next = S0;
    endcase
  end

  // Pulse is registered from the next-state decode so it coincides with state == SF.
  always_ff @(posedge i_clk) begin
    if (i_resetn) begin
      o_pattern_found <= 1'b0;
    end else begin
      o_pattern_found <= (state_next == SF);
    end
  end

endmodule

// File: tb/tb_sequence_detector_fsm_101001.sv
// Directed-vector bench for sequence_detector_fsm_101001, both OVERLAP settings side by side.
module tb_sequence_detector_fsm_101001;

  logic clk;
  logic resetn;
  logic data;
  logic found_ov;
  logic found_no;

  int n_checks = 0;
  int n_errors = 0;

  sequence_detector_fsm_101001 #(.OVERLAP(1'b1)) dut_ov (
    .i_clk          (clk),
    .i_resetn       (resetn),
    .i_data         (data),
    .o_pattern_found(found_ov)
  );

  sequence_detector_fsm_101001 #(.OVERLAP(1'b0)) dut_no (
    .i_clk          (clk),
    .i_resetn       (resetn),
    .i_data         (data),
    .o_pattern_found(found_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one bit, clock it in, then check both outputs just after the edge.
  task automatic step(input string tag, input logic rst, input logic b,
                      input logic exp_ov, input logic exp_no);
    resetn = rst;
    data   = b;
    @(posedge clk);
    #1;
    check({tag, "/ov"}, found_ov, exp_ov);
    check({tag, "/no"}, found_no, exp_no);
  endtask

  task automatic do_reset();
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Bits and expected pulses are listed MSB first, one bit per cycle.
  task automatic run_seq(input string tag, input logic [31:0] bits, input int n,
                         input logic [31:0] exp_ov, input logic [31:0] exp_no);
    do_reset();
    for (int i = n - 1; i >= 0; i--) begin
      step(tag, 1'b0, bits[i], exp_ov[i], exp_no[i]);
    end
  endtask

  task automatic run_random(input int nbits);
    logic [5:0] sh;
    int cnt_ov;
    int cnt_no;
    logic b;
    logic m_ov;
    logic m_no;
    do_reset();
    sh = '0;
    cnt_ov = 0;
    cnt_no = 0;
    for (int i = 0; i < nbits; i++) begin
      b = (($urandom % 4) != 0) ? logic'(i % 2 == 0) ^ logic'($urandom % 2) : logic'($urandom % 2);
      sh = {sh[4:0], b};
      if (cnt_ov < 6) cnt_ov++;
      if (cnt_no < 6) cnt_no++;
      m_ov = (cnt_ov >= 6) && (sh == 6'b101001);
      m_no = (cnt_no >= 6) && (sh == 6'b101001);
      if (m_no) cnt_no = 0;
      step("random", 1'b0, b, m_ov, m_no);
    end
  endtask

  initial begin
    resetn = 1'b1;
    data   = 1'b0;

    // Reset held while the full pattern is presented: no pulse, none after release.
    for (int i = 0; i < 10; i++) begin
      step("rst_hold", 1'b1, logic'((6'b101001 >> (5 - (i % 6))) & 1), 1'b0, 1'b0);
    end
    step("rst_release", 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst_release", 1'b0, 1'b1, 1'b0, 1'b0);

    run_seq("basic",    32'b1010010,     7,  32'b0000010,     32'b0000010);
    run_seq("overlap",  32'b10100101001, 11, 32'b00000100001, 32'b00000100000);
    run_seq("miss_s3",  32'b101101001,   9,  32'b000000001,   32'b000000001);
    run_seq("miss_s4",  32'b10101001,    8,  32'b00000001,    32'b00000001);
    run_seq("miss_s5",  32'b1010001,     7,  32'b0000000,     32'b0000000);
    run_seq("chain",    32'b1010010100101001, 16,
            32'b0000010000100001, 32'b0000010000000001);

    // Reset mid-sequence discards the "10100" prefix.
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      step("mid_rst_pre", 1'b0, logic'((5'b10100 >> i) & 1), 1'b0, 1'b0);
    end
    step("mid_rst", 1'b1, 1'b1, 1'b0, 1'b0);
    step("mid_rst_post", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      step("mid_rst_full", 1'b0, logic'((5'b01001 >> i) & 1),
           logic'(i == 0), logic'(i == 0));
    end
    step("mid_rst_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted while the pulse is due suppresses it.
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      step("rst_at_sf", 1'b0, logic'((5'b10100 >> i) & 1), 1'b0, 1'b0);
    end
    step("rst_at_sf", 1'b1, 1'b1, 1'b0, 1'b0);

    run_random(2500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
